// File: rtl/id_stage_hz_if.sv
// Signal bundle between the IF/ID latch, the writeback port and the ID/EX register of id_stage_hz.
interface id_stage_hz_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // IF/ID offers instr while if_id_valid=1. The instruction is taken on a rising edge only
    // when stall=0; while stall=1 the IF/ID side must hold it. id_ex_valid marks a real EX op.
    logic            if_id_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] if_id_npc;
    logic            wb_regwrite;
    logic [AW-1:0]   wb_writereg;
    logic [XLEN-1:0] wb_writedata;
    logic            flush;
    logic            stall;
    logic            id_ex_valid;
    logic [1:0]      id_ex_wb;
    logic [2:0]      id_ex_m;
    logic [3:0]      id_ex_ex;
    logic [XLEN-1:0] id_ex_npc;
    logic [XLEN-1:0] id_ex_reg1;
    logic [XLEN-1:0] id_ex_reg2;
    logic [XLEN-1:0] id_ex_sign_ext;
    logic [AW-1:0]   id_ex_rs;
    logic [AW-1:0]   id_ex_rt;
    logic [AW-1:0]   id_ex_rd;

    modport slave (
        input  if_id_valid, instr, if_id_npc, wb_regwrite, wb_writereg, wb_writedata, flush,
        output stall, id_ex_valid, id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_reg1,
               id_ex_reg2, id_ex_sign_ext, id_ex_rs, id_ex_rt, id_ex_rd
    );

    modport master (
        output if_id_valid, instr, if_id_npc, wb_regwrite, wb_writereg, wb_writedata, flush,
        input  stall, id_ex_valid, id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_reg1,
               id_ex_reg2, id_ex_sign_ext, id_ex_rs, id_ex_rt, id_ex_rd
    );
endinterface

// File: rtl/id_stage_hz.sv
// Decode stage: control decode, register file with WB bypass, load-use hazard detection,
// flush handling and the ID/EX pipeline register.
module id_stage_hz #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input logic          clk,
    input logic          rst,
    id_stage_hz_if.slave bus
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic [5:0]      opcode;
    logic [15:0]     imm;
    logic [31:0]     rs_w, rt_w, rd_w;
    logic [AW-1:0]   rs, rt, rd;
    logic [8:0]      ctrl;
    logic [XLEN-1:0] sext, rdata1, rdata2;
    logic            wr_en, load_use, bubble;

    logic            id_ex_valid_q, id_ex_valid_d;
    logic [1:0]      id_ex_wb_q, id_ex_wb_d;
    logic [2:0]      id_ex_m_q, id_ex_m_d;
    logic [3:0]      id_ex_ex_q, id_ex_ex_d;
    logic [XLEN-1:0] id_ex_npc_q, id_ex_npc_d;
    logic [XLEN-1:0] id_ex_reg1_q, id_ex_reg1_d;
    logic [XLEN-1:0] id_ex_reg2_q, id_ex_reg2_d;
    logic [XLEN-1:0] id_ex_sext_q, id_ex_sext_d;
    logic [AW-1:0]   id_ex_rs_q, id_ex_rs_d;
    logic [AW-1:0]   id_ex_rt_q, id_ex_rt_d;
    logic [AW-1:0]   id_ex_rd_q, id_ex_rd_d;

    // r0 and addresses beyond the implemented registers are hardwired to zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < 32'(NREGS));
    endfunction

    always_comb begin
        opcode = bus.instr[31:26];
        imm    = bus.instr[15:0];
        rs_w   = {27'd0, bus.instr[25:21]};
        rt_w   = {27'd0, bus.instr[20:16]};
        rd_w   = {27'd0, bus.instr[15:11]};
        rs     = rs_w[AW-1:0];
        rt     = rt_w[AW-1:0];
        rd     = rd_w[AW-1:0];
        sext   = {{(XLEN-16){imm[15]}}, imm};
        case (opcode)
            OP_R:    ctrl = 9'b10_000_1100;
            OP_LW:   ctrl = 9'b11_010_0001;
            OP_SW:   ctrl = 9'b00_001_0001;
            OP_BEQ:  ctrl = 9'b00_100_0010;
            OP_ADDI: ctrl = 9'b10_000_0001;
            default: ctrl = 9'b00_000_0000;
        endcase
    end

    // Same-cycle writeback is forwarded so ID never reads a value one cycle stale.
    always_comb begin
        wr_en  = bus.wb_regwrite && addr_ok(bus.wb_writereg);
        rdata1 = '0;
        rdata2 = '0;
        if (addr_ok(rs)) rdata1 = (wr_en && bus.wb_writereg == rs) ? bus.wb_writedata : regs_q[rs];
        if (addr_ok(rt)) rdata2 = (wr_en && bus.wb_writereg == rt) ? bus.wb_writedata : regs_q[rt];
        for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
        if (wr_en) regs_d[bus.wb_writereg] = bus.wb_writedata;
    end

    always_comb begin
        load_use = bus.if_id_valid && !bus.flush && id_ex_valid_q && id_ex_m_q[1] &&
                   (id_ex_rt_q != '0) &&
                   ((id_ex_rt_q == rs) ||
                    ((id_ex_rt_q == rt) && (opcode == OP_R || opcode == OP_SW || opcode == OP_BEQ)));
        bubble        = bus.flush || load_use || !bus.if_id_valid;
        id_ex_valid_d = !bubble;
        id_ex_wb_d    = bubble ? 2'b00  : ctrl[8:7];
        id_ex_m_d     = bubble ? 3'b000 : ctrl[6:4];
        id_ex_ex_d    = bubble ? 4'b0000 : ctrl[3:0];
        id_ex_npc_d   = bus.if_id_npc;
        id_ex_reg1_d  = rdata1;
        id_ex_reg2_d  = rdata2;
        id_ex_sext_d  = sext;
        id_ex_rs_d    = rs;
        id_ex_rt_d    = rt;
        id_ex_rd_d    = rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_valid_q <= 1'b0;
            id_ex_wb_q    <= '0;
            id_ex_m_q     <= '0;
            id_ex_ex_q    <= '0;
            id_ex_npc_q   <= '0;
            id_ex_reg1_q  <= '0;
            id_ex_reg2_q  <= '0;
            id_ex_sext_q  <= '0;
            id_ex_rs_q    <= '0;
            id_ex_rt_q    <= '0;
            id_ex_rd_q    <= '0;
        end else begin
            id_ex_valid_q <= id_ex_valid_d;
            id_ex_wb_q    <= id_ex_wb_d;
            id_ex_m_q     <= id_ex_m_d;
            id_ex_ex_q    <= id_ex_ex_d;
            id_ex_npc_q   <= id_ex_npc_d;
            id_ex_reg1_q  <= id_ex_reg1_d;
            id_ex_reg2_q  <= id_ex_reg2_d;
            id_ex_sext_q  <= id_ex_sext_d;
            id_ex_rs_q    <= id_ex_rs_d;
            id_ex_rt_q    <= id_ex_rt_d;
            id_ex_rd_q    <= id_ex_rd_d;
        end
    end

    assign bus.stall          = load_use;
    assign bus.id_ex_valid    = id_ex_valid_q;
    assign bus.id_ex_wb       = id_ex_wb_q;
    assign bus.id_ex_m        = id_ex_m_q;
    assign bus.id_ex_ex       = id_ex_ex_q;
    assign bus.id_ex_npc      = id_ex_npc_q;
    assign bus.id_ex_reg1     = id_ex_reg1_q;
    assign bus.id_ex_reg2     = id_ex_reg2_q;
    assign bus.id_ex_sign_ext = id_ex_sext_q;
    assign bus.id_ex_rs       = id_ex_rs_q;
    assign bus.id_ex_rt       = id_ex_rt_q;
    assign bus.id_ex_rd       = id_ex_rd_q;
endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: scenario tasks push expected ID/EX contents and compare one cycle later.
module tb_id_stage_hz;
    localparam int PW = 153;
    localparam logic [PW-1:0] M_ALL  = {PW{1'b1}};
    localparam logic [PW-1:0] M_CTRL = {{10{1'b1}}, {(PW-10){1'b0}}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_hz_if #(.XLEN(32), .AW(5)) bus ();
    id_stage_hz_if #(.XLEN(64), .AW(5)) bus64 ();

    id_stage_hz #(.XLEN(32), .NREGS(32), .AW(5)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    id_stage_hz #(.XLEN(64), .NREGS(32), .AW(5)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] msk_q[$];
    logic [PW-1:0] got, e, mk;
    logic [31:0]   npc_v;
    int            n_chk = 0;
    int            n_pass = 0;

    function automatic logic [PW-1:0] exp_v(input logic v, input logic [1:0] wb, input logic [2:0] m,
                                            input logic [3:0] ex, input logic [31:0] npc,
                                            input logic [31:0] r1, input logic [31:0] r2,
                                            input logic [31:0] se, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd);
        return {v, wb, m, ex, npc, r1, r2, se, rs, rt, rd};
    endfunction

    function automatic logic [PW-1:0] pack_out();
        return {bus.id_ex_valid, bus.id_ex_wb, bus.id_ex_m, bus.id_ex_ex, bus.id_ex_npc,
                bus.id_ex_reg1, bus.id_ex_reg2, bus.id_ex_sign_ext, bus.id_ex_rs,
                bus.id_ex_rt, bus.id_ex_rd};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic wbe,
                         input logic [4:0] wbr, input logic [31:0] wbd, input logic fl);
        @(negedge clk);
        npc_v            = $urandom_range(0, 32'h3FFF_FFFF) << 2;
        bus.if_id_valid  = v;
        bus.instr        = ins;
        bus.if_id_npc    = npc_v;
        bus.wb_regwrite  = wbe;
        bus.wb_writereg  = wbr;
        bus.wb_writedata = wbd;
        bus.flush        = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 0);
        #1;
        n_chk++;
        if (pack_out() !== '0) $display("FAIL reset_outputs got=%h exp=0", pack_out());
        else n_pass++;
        n_chk++;
        if (bus.stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.stall);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        drive(0, 32'h0, 1, 5'd1, 32'd5, 0);
        exp_q.push_back('0); msk_q.push_back(M_CTRL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL rtype_pre1 got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
        drive(0, 32'h0, 1, 5'd2, 32'd7, 0);
        exp_q.push_back('0); msk_q.push_back(M_CTRL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL rtype_pre2 got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
        drive(1, 32'h0022_1820, 0, 0, 0, 0);
        exp_q.push_back(exp_v(1, 2'b10, 3'b000, 4'b1100, npc_v, 32'd5, 32'd7, 32'h1820, 5'd1, 5'd2, 5'd3));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL rtype_add got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
    endtask

    task automatic test_bypass();
        drive(1, 32'h0080_2820, 1, 5'd4, 32'hDEAD_BEEF, 0);
        exp_q.push_back(exp_v(1, 2'b10, 3'b000, 4'b1100, npc_v, 32'hDEAD_BEEF, 32'd0, 32'h2820, 5'd4, 5'd0, 5'd5));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL bypass_r4 got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
        drive(0, 32'h0, 1, 5'd0, 32'h0000_1234, 0);
        exp_q.push_back('0); msk_q.push_back(M_CTRL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL bypass_r0_wr got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
        drive(1, 32'h0004_3020, 1, 5'd0, 32'h0000_5678, 0);
        exp_q.push_back(exp_v(1, 2'b10, 3'b000, 4'b1100, npc_v, 32'd0, 32'hDEAD_BEEF, 32'h3020, 5'd0, 5'd4, 5'd6));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL bypass_r0_rd got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
    endtask

    task automatic test_load_use();
        drive(1, 32'h8C08_0004, 0, 0, 0, 0);
        exp_q.push_back(exp_v(1, 2'b11, 3'b010, 4'b0001, npc_v, 32'd0, 32'd0, 32'd4, 5'd0, 5'd8, 5'd0));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL lu_lw got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
        drive(1, 32'h0108_4820, 1, 5'd8, 32'h55, 0);
        #1; n_chk++;
        if (bus.stall !== 1'b1) $display("FAIL lu_stall_on got=%b exp=1", bus.stall);
        else n_pass++;
        exp_q.push_back('0); msk_q.push_back(M_CTRL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL lu_bubble got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
        drive(1, 32'h0108_4820, 0, 0, 0, 0);
        #1; n_chk++;
        if (bus.stall !== 1'b0) $display("FAIL lu_stall_off got=%b exp=0", bus.stall);
        else n_pass++;
        exp_q.push_back(exp_v(1, 2'b10, 3'b000, 4'b1100, npc_v, 32'h55, 32'h55, 32'h4820, 5'd8, 5'd8, 5'd9));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL lu_issue got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
    endtask

    task automatic test_no_hazard();
        drive(1, 32'h8C08_0004, 0, 0, 0, 0);
        exp_q.push_back(exp_v(1, 2'b11, 3'b010, 4'b0001, npc_v, 32'd0, 32'h55, 32'd4, 5'd0, 5'd8, 5'd0));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL nh_lw got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
        drive(1, 32'h2008_0001, 0, 0, 0, 0);
        #1; n_chk++;
        if (bus.stall !== 1'b0) $display("FAIL nh_addi_rt_stall got=%b exp=0", bus.stall);
        else n_pass++;
        exp_q.push_back(exp_v(1, 2'b10, 3'b000, 4'b0001, npc_v, 32'd0, 32'h55, 32'd1, 5'd0, 5'd8, 5'd0));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL nh_addi got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
    endtask

    task automatic test_sign_ext();
        logic [31:0] ins_t [2];
        logic [31:0] se32_t [2];
        logic [63:0] se64_t [2];
        logic [4:0]  rd_t [2];
        ins_t[0] = 32'h200A_FFFC; se32_t[0] = 32'hFFFF_FFFC; se64_t[0] = 64'hFFFF_FFFF_FFFF_FFFC; rd_t[0] = 5'h1F;
        ins_t[1] = 32'h200A_7FFC; se32_t[1] = 32'h0000_7FFC; se64_t[1] = 64'h0000_0000_0000_7FFC; rd_t[1] = 5'h0F;
        for (int i = 0; i < 2; i++) begin
            drive(1, ins_t[i], 0, 0, 0, 0);
            bus64.if_id_valid = 1'b1;
            bus64.instr       = ins_t[i];
            exp_q.push_back(exp_v(1, 2'b10, 3'b000, 4'b0001, npc_v, 32'd0, 32'd0, se32_t[i], 5'd0, 5'd10, rd_t[i]));
            msk_q.push_back(M_ALL);
            tick();
            got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
            if ((got & mk) !== (e & mk)) $display("FAIL sext32[%0d] got=%h exp=%h", i, got & mk, e & mk);
            else n_pass++;
            n_chk++;
            if ({bus64.id_ex_valid, bus64.id_ex_ex, bus64.id_ex_sign_ext} !== {1'b1, 4'b0001, se64_t[i]})
                $display("FAIL sext64[%0d] got=%b/%h/%h exp=1/0001/%h", i, bus64.id_ex_valid,
                         bus64.id_ex_ex, bus64.id_ex_sign_ext, se64_t[i]);
            else n_pass++;
        end
        @(negedge clk);
        bus64.if_id_valid = 1'b0;
    endtask

    task automatic test_flush();
        drive(1, 32'h8C08_0004, 0, 0, 0, 0);
        exp_q.push_back(exp_v(1, 2'b11, 3'b010, 4'b0001, npc_v, 32'd0, 32'h55, 32'd4, 5'd0, 5'd8, 5'd0));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL fl_lw got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
        drive(1, 32'h0108_4820, 0, 0, 0, 1);
        #1; n_chk++;
        if (bus.stall !== 1'b0) $display("FAIL fl_stall got=%b exp=0", bus.stall);
        else n_pass++;
        exp_q.push_back('0); msk_q.push_back(M_CTRL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL fl_bubble got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
        drive(1, 32'hFC22_1820, 0, 0, 0, 0);
        exp_q.push_back(exp_v(1, 2'b00, 3'b000, 4'b0000, npc_v, 32'd5, 32'd7, 32'h1820, 5'd1, 5'd2, 5'd3));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL fl_unknown_op got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h200A_FFFC, 0, 0, 0, 0);
        exp_q.push_back(exp_v(1, 2'b10, 3'b000, 4'b0001, npc_v, 32'd0, 32'd0, 32'hFFFF_FFFC, 5'd0, 5'd10, 5'h1F));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL rm_pre got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1; n_chk++;
        if (pack_out() !== '0) $display("FAIL rm_async_clear got=%h exp=0", pack_out());
        else n_pass++;
        drive(0, 32'h0, 1, 5'd1, 32'h99, 0);
        drive(1, 32'h0022_1820, 0, 0, 0, 0);
        rst = 1'b0;
        exp_q.push_back(exp_v(1, 2'b10, 3'b000, 4'b1100, npc_v, 32'd0, 32'd0, 32'h1820, 5'd1, 5'd2, 5'd3));
        msk_q.push_back(M_ALL);
        tick();
        got = pack_out(); e = exp_q.pop_front(); mk = msk_q.pop_front(); n_chk++;
        if ((got & mk) !== (e & mk)) $display("FAIL rm_regs_cleared got=%h exp=%h", got & mk, e & mk);
        else n_pass++;
    endtask

    initial begin
        bus64.if_id_valid  = 1'b0;
        bus64.instr        = '0;
        bus64.if_id_npc    = '0;
        bus64.wb_regwrite  = 1'b0;
        bus64.wb_writereg  = '0;
        bus64.wb_writedata = '0;
        bus64.flush        = 1'b0;
        test_reset();
        test_rtype();
        test_bypass();
        test_load_use();
        test_no_hazard();
        test_sign_ext();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised successor to the pipeline decode stage: control decode, register file, sign extension and ID/EX pipeline register in one block.
- Adds an explicit writeback address, a WB-to-ID write-through bypass, load-use hazard detection with bubble insertion, a flush input and a valid bit carried into EX.
- Sits between the IF/ID latch and the EX stage. Register width and register count are parametrised.

Parameters:
- XLEN, 32, datapath width of registers, npc and sign-extended immediate.
- NREGS, 32, number of architectural registers; register 0 reads as zero and ignores writes.
- AW, 5, register address width; NREGS <= 2**AW; addresses >= NREGS read 0 and ignore writes.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- if_id_valid  in  1  instruction in IF/ID is real (0 = bubble)
- instr  in  32  instruction from IF/ID; rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0], opcode = [31:26]; register fields are zero-extended or truncated to AW
- if_id_npc  in  XLEN  next PC from IF/ID
- wb_regwrite  in  1  writeback enable
- wb_writereg  in  AW  writeback destination
- wb_writedata  in  XLEN  writeback data
- flush  in  1  squash the instruction currently in ID
- stall  out  1  combinational; IF and IF/ID must hold this cycle
- id_ex_valid  out  1  EX-stage instruction is real
- id_ex_wb  out  2  [1] RegWrite, [0] MemToReg
- id_ex_m  out  3  [2] Branch, [1] MemRead, [0] MemWrite
- id_ex_ex  out  4  [3] RegDst, [2:1] ALUOp, [0] ALUSrc
- id_ex_npc, id_ex_reg1, id_ex_reg2, id_ex_sign_ext  out  XLEN  latched values
- id_ex_rs, id_ex_rt, id_ex_rd  out  AW  latched register fields

Behaviour:
- Decode (combinational), values given as {wb, m, ex}:
  - opcode 0x00 (R-type): {10, 000, 1100}
  - 0x23 (lw): {11, 010, 0001}
  - 0x2B (sw): {00, 001, 0001}
  - 0x04 (beq): {00, 100, 0010}
  - 0x08 (addi): {10, 000, 0001}
  - any other opcode: all zero.
- Sign extension: replicate imm[15] to XLEN bits.
- Register file:
  - Writes occur at posedge when wb_regwrite=1 and wb_writereg is not 0 and < NREGS.
  - Reads are combinational.
  - Bypass: if wb_regwrite=1, wb_writereg==read address, and the address is nonzero and valid, the read returns wb_writedata in the same cycle.
- Hazard detection: stall=1 iff all of the following hold:
  - if_id_valid=1
  - flush=0
  - id_ex_valid=1
  - id_ex_m[1]=1
  - id_ex_rt != 0
  - id_ex_rt == rs, or (id_ex_rt == rt and opcode is one of 0x00, 0x2B, 0x04)
- ID/EX latch (posedge), priority order:
  - rst: every output is 0, including id_ex_valid; asynchronous, so outputs clear immediately on rst assertion. The register file also clears to all zeros.
  - flush=1 or stall=1 or if_id_valid=0: insert a bubble. id_ex_valid, id_ex_wb, id_ex_m and id_ex_ex all go to 0; the data fields load from their inputs (don't-care).
  - otherwise: load all decoded and read values, with id_ex_valid=1.
- Flush overrides stall; stall is 0 whenever flush=1.
- Latency: one cycle from ID inputs to id_ex_* outputs. A load-use pair costs exactly one bubble.
- A writeback in the same cycle as a stall is still performed. The re-read in the following cycle sees the new value.
- Reset asserted mid-operation discards the in-flight instruction. No writeback is performed while rst=1.

Test Plan:
- Reset: assert rst mid-run with id_ex_valid=1 -> all outputs 0 immediately; a read of any register after release returns 0.
- R-type decode: preload r1=5 and r2=7, then instr=0x00221820 (add r3,r1,r2) -> next cycle id_ex_ex=1100, id_ex_wb=10, reg1=5, reg2=7, id_ex_rd=3, id_ex_valid=1.
- Bypass and r0: wb writes r4=0xDEADBEEF in the same cycle ID reads r4 -> id_ex_reg1=0xDEADBEEF. A wb write to r0 followed by a read of r0 -> 0.
- Load-use stall: lw r8,4(r0) (0x8C080004), then add r9,r8,r8 -> stall=1 for exactly one cycle and a bubble with id_ex_valid=0; the add issues the next cycle.
- Sign extension: addi with imm=0xFFFC -> id_ex_sign_ext=0xFFFFFFFC and id_ex_ex=0001. A second run with XLEN=64 -> 0xFFFFFFFFFFFFFFFC.
- Flush over stall: a load-use pair with flush=1 on the dependent cycle -> stall=0, bubble inserted; an unknown opcode 0x3F -> all controls 0 with id_ex_valid=1.
